// File: rtl/cachemem_pkg.sv
// cachemem_pkg: shared fill-FSM state type and index/beat field helpers for cachemem_ways
package cachemem_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_DONE} fill_state_t;

    // Field width that stays at least one bit wide for degenerate counts
    function automatic int min1_clog2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // First word index of the line containing idx
    function automatic int line_base(input int idx, input int log_beats);
        return idx & ~((1 << log_beats) - 1);
    endfunction

    // Word index of a beat inside an aligned line
    function automatic int beat_index(input int base, input int beat);
        return base | beat;
    endfunction

endpackage

// File: rtl/cachemem_bank.sv
// cachemem_bank: one cache way built from byte-wide simple dual-port RAMs with per-lane write enables
module cachemem_bank
    import cachemem_pkg::*;
#(
    parameter int DATAWIDTH = 64,
    parameter int DEPTH     = 2048,
    localparam int CSWIDTH  = DATAWIDTH / 8,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 i_rd_en,
    input  logic [AW-1:0]        i_rd_idx,
    output logic [DATAWIDTH-1:0] o_rd_data,
    input  logic [CSWIDTH-1:0]   i_wr_be,
    input  logic [AW-1:0]        i_wr_idx,
    input  logic [DATAWIDTH-1:0] i_wr_data
);

    for (genvar g = 0; g < CSWIDTH; g++) begin : g_lane
        logic [7:0] r_mem [DEPTH];
        logic [7:0] r_q;
        // Read-before-write byte lane; the read register holds when not enabled
        always_ff @(posedge clk) begin
            if (i_wr_be[g]) r_mem[i_wr_idx] <= i_wr_data[g*8 +: 8];
            if (i_rd_en) r_q <= r_mem[i_rd_idx];
        end
        assign o_rd_data[g*8 +: 8] = r_q;
    end

endmodule

// File: rtl/cachemem_ways.sv
// cachemem_ways: N-way byte-writable cache data store with line-refill engine; CACHEMEM_BYPASS_EN enables read-during-write forwarding
module cachemem_ways
    import cachemem_pkg::*;
#(
    parameter int DATAWIDTH  = 64,
    parameter int DEPTH      = 2048,
    parameter int WAYS       = 2,
    parameter int LINE_BEATS = 4,
    localparam int CSWIDTH   = DATAWIDTH / 8,
    localparam int AW        = $clog2(DEPTH),
    localparam int LB        = $clog2(CSWIDTH),
    localparam int WW        = min1_clog2(WAYS),
    localparam int BW        = min1_clog2(LINE_BEATS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_rd_en,
    input  logic [AW+LB-1:0]     i_rd_addr,
    input  logic [WW-1:0]        i_rd_way,
    output logic                 o_rd_valid,
    output logic [DATAWIDTH-1:0] o_rd_data,
    input  logic                 i_wr_en,
    output logic                 o_wr_ready,
    input  logic [AW+LB-1:0]     i_wr_addr,
    input  logic [WW-1:0]        i_wr_way,
    input  logic [CSWIDTH-1:0]   i_wr_bsel,
    input  logic [DATAWIDTH-1:0] i_wr_data,
    input  logic                 i_fill_start,
    input  logic [AW+LB-1:0]     i_fill_addr,
    input  logic [WW-1:0]        i_fill_way,
    input  logic                 i_fill_valid,
    input  logic [DATAWIDTH-1:0] i_fill_data,
    output logic                 o_fill_ready,
    output logic                 o_fill_busy,
    output logic                 o_fill_done
);

    localparam int LOGB = $clog2(LINE_BEATS);

    fill_state_t          r_state;
    logic [BW-1:0]        r_cnt;
    logic [AW-1:0]        r_base;
    logic [WW-1:0]        r_fill_way;
    logic                 r_fill_busy;
    logic                 r_fill_ready;
    logic                 r_fill_done;
    logic                 r_rd_valid;
    logic [WW-1:0]        r_rd_way;
    logic [DATAWIDTH-1:0] r_rd_hold;

    logic                 w_fill_wr;
    logic                 w_cpu_wr;
    logic                 w_we;
    logic [WW-1:0]        w_wway;
    logic [AW-1:0]        w_widx;
    logic [CSWIDTH-1:0]   w_wbe;
    logic [DATAWIDTH-1:0] w_wdata;
    logic [AW-1:0]        w_rd_idx;
    logic [DATAWIDTH-1:0] w_bank_q [WAYS];
    logic [DATAWIDTH-1:0] w_rd_word;
    logic                 w_unused;

    assign w_fill_wr = (r_state == ST_FILL) && i_fill_valid;
    assign w_cpu_wr  = i_wr_en && !r_fill_busy;
    assign w_we      = w_fill_wr || w_cpu_wr;
    assign w_wway    = w_fill_wr ? r_fill_way : i_wr_way;
    assign w_widx    = w_fill_wr ? AW'(beat_index(int'(r_base), int'(r_cnt))) : i_wr_addr[AW+LB-1:LB];
    assign w_wbe     = w_fill_wr ? '1 : (w_cpu_wr ? i_wr_bsel : '0);
    assign w_wdata   = w_fill_wr ? i_fill_data : i_wr_data;
    assign w_rd_idx  = i_rd_addr[AW+LB-1:LB];
    assign w_unused  = ^{i_rd_addr[LB-1:0], i_wr_addr[LB-1:0], i_fill_addr[LB-1:0]};

    assign o_wr_ready   = !r_fill_busy;
    assign o_fill_busy  = r_fill_busy;
    assign o_fill_ready = r_fill_ready;
    assign o_fill_done  = r_fill_done;
    assign o_rd_valid   = r_rd_valid;
    assign o_rd_data    = r_rd_valid ? w_rd_word : r_rd_hold;

    for (genvar g = 0; g < WAYS; g++) begin : g_way
        cachemem_bank #(
            .DATAWIDTH (DATAWIDTH),
            .DEPTH     (DEPTH)
        ) u_bank (
            .clk       (clk),
            .i_rd_en   (i_rd_en && (i_rd_way == WW'(g))),
            .i_rd_idx  (w_rd_idx),
            .o_rd_data (w_bank_q[g]),
            .i_wr_be   ((w_we && (w_wway == WW'(g))) ? w_wbe : '0),
            .i_wr_idx  (w_widx),
            .i_wr_data (w_wdata)
        );
    end

    // Line-refill FSM with registered busy/ready/done flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_base       <= '0;
            r_fill_way   <= '0;
            r_fill_busy  <= 1'b0;
            r_fill_ready <= 1'b0;
            r_fill_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: if (i_fill_start) begin
                    r_state      <= ST_FILL;
                    r_base       <= AW'(line_base(int'(i_fill_addr[AW+LB-1:LB]), LOGB));
                    r_fill_way   <= i_fill_way;
                    r_cnt        <= '0;
                    r_fill_busy  <= 1'b1;
                    r_fill_ready <= 1'b1;
                end
                ST_FILL: if (i_fill_valid) begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == BW'(LINE_BEATS - 1)) begin
                        r_state      <= ST_DONE;
                        r_fill_ready <= 1'b0;
                        r_fill_done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state     <= ST_IDLE;
                    r_fill_done <= 1'b0;
                    r_fill_busy <= 1'b0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Read tracking: valid flag, selected way, and the held word shown while idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_valid <= 1'b0;
            r_rd_way   <= '0;
            r_rd_hold  <= '0;
        end else begin
            r_rd_valid <= i_rd_en;
            if (i_rd_en) r_rd_way <= i_rd_way;
            if (r_rd_valid) r_rd_hold <= w_rd_word;
        end
    end

`ifdef CACHEMEM_BYPASS_EN
    logic                 r_byp_hit;
    logic [CSWIDTH-1:0]   r_byp_be;
    logic [DATAWIDTH-1:0] r_byp_data;

    // Capture the write that collides with this cycle's read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_byp_hit  <= 1'b0;
            r_byp_be   <= '0;
            r_byp_data <= '0;
        end else begin
            r_byp_hit  <= i_rd_en && w_we && (w_wway == i_rd_way) && (w_widx == w_rd_idx);
            r_byp_be   <= w_wbe;
            r_byp_data <= w_wdata;
        end
    end

    // Merge freshly written lanes over the old word from the array
    always_comb begin
        w_rd_word = w_bank_q[r_rd_way];
        for (int i = 0; i < CSWIDTH; i++)
            if (r_byp_hit && r_byp_be[i]) w_rd_word[i*8 +: 8] = r_byp_data[i*8 +: 8];
    end
`else
    assign w_rd_word = w_bank_q[r_rd_way];
`endif

endmodule

// File: doc/cachemem_ways.md
# cachemem_ways

N-way, byte-lane-writable cache data store with a line-refill engine. It extends the single-way byte-enable dual-port array to `WAYS` ways. It adds a registered, valid-flagged read port and a handshaked burst-fill port that writes a whole line of `LINE_BEATS` words. It also has optional read-during-write forwarding. It sits between the cache controller (tag/hit logic, CPU store path) and the bus refill master.

## Interface
Parameters:
- DATAWIDTH, 64, word width in bits; must be a multiple of 8
- DEPTH, 2048, words per way; power of 2
- WAYS, 2, number of ways; power of 2, ≥1
- LINE_BEATS, 4, words per cache line; power of 2, ≤DEPTH
- derived: CSWIDTH=DATAWIDTH/8, AW=$clog2(DEPTH), LB=$clog2(CSWIDTH), WW=max(1,$clog2(WAYS)), BW=max(1,$clog2(LINE_BEATS))

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst_n  in  1  asynchronous active-low reset
- rd_en  in  1  read request
- rd_addr  in  AW+LB  byte address; index = rd_addr[AW+LB-1:LB]
- rd_way  in  WW  way to read
- rd_valid  out  1  rd_data is valid for the read issued the previous cycle
- rd_data  out  DATAWIDTH  read data; holds its value when rd_valid=0
- wr_en  in  1  CPU store; accepted only when wr_ready=1
- wr_ready  out  1  equals !fill_busy
- wr_addr  in  AW+LB  store byte address
- wr_way  in  WW  store way
- wr_bsel  in  CSWIDTH  byte enables
- wr_data  in  DATAWIDTH  store data
- fill_start  in  1  begin line refill; sampled only in IDLE
- fill_addr  in  AW+LB  any byte address inside the target line
- fill_way  in  WW  refill way
- fill_valid  in  1  refill beat present
- fill_data  in  DATAWIDTH  refill beat data
- fill_ready  out  1  engine accepts a beat this cycle
- fill_busy  out  1  engine not IDLE
- fill_done  out  1  one-cycle pulse after the last beat is written

## Operation
- Fill FSM states: IDLE, FILL, DONE.
  - IDLE → FILL on fill_start. The FSM latches base index = fill_addr index with its low BW bits forced to 0, latches fill_way, and clears beat counter cnt.
  - FILL: fill_ready=1. Each cycle with fill_valid=1 writes fill_data with all byte lanes enabled to base|cnt, then cnt increments. When fill_valid=1 and cnt==LINE_BEATS-1, the FSM goes to DONE.
  - DONE: fill_done=1 for one cycle, then IDLE.
- fill_start outside IDLE is ignored. fill_valid outside FILL is ignored.
- Beats never cross the line boundary, because the base is aligned and cnt is BW bits.
- Write-port mux:
  - In FILL with fill_valid: the fill beat is written.
  - Otherwise, wr_en && wr_ready writes wr_data to the wr_way array. Only lanes with wr_bsel=1 are written.
  - wr_en while wr_ready=0 is dropped; the controller must hold the store and retry.
- Reads are always accepted, including during a fill. Only way rd_way is read.
- Read/write collision: same way and same index in the same cycle, as described under Configuration.
- Reset:
  - Outputs: rd_valid=0, rd_data=0, fill_busy=0, fill_ready=0, fill_done=0, wr_ready=1.
  - FSM goes to IDLE and cnt=0.
  - The RAM array is not reset.
  - Reset mid-fill abandons the line; the contents of beats already written are unspecified to the controller, which must invalidate the tag.

## Timing
- Read latency is 1 cycle: rd_en at edge N gives rd_valid=1 and rd_data during cycle N+1. Back-to-back reads give one result per cycle.
- A write at edge N is visible to a non-colliding read issued at edge N+1.
- Fill of L beats with fill_valid continuously high:
  - fill_start at edge N puts the FSM in FILL for cycle N+1.
  - Beats are written at edges N+1 through N+L.
  - fill_done is high in cycle N+L+1.
  - wr_ready returns to 1 in cycle N+L+2.
- fill_valid gaps stall cnt with no timeout.

## Configuration
- CACHEMEM_BYPASS_EN defined: a colliding read returns merged data per byte. Lanes being written this cycle take the new data; other lanes take the old data. This costs a registered copy of the write data, the byte mask and a hit flag, and the merge is applied at the output.
- CACHEMEM_BYPASS_EN undefined: a colliding read returns the old word (read-before-write), and no forwarding logic is built.

## Structure
- Package cachemem_pkg holds:
  - the fill FSM state enum (IDLE, FILL, DONE)
  - helper functions for the index and beat fields
- Sub-module cachemem_bank: one way.
  - CSWIDTH byte-wide simple dual-port synchronous RAMs: one read port, one write port, per-lane write enable.
  - No reset.
  - cachemem_ways instantiates it WAYS times and muxes the read data by the registered rd_way.

## Test plan
- Reset, then read way0 addr 0x10 → rd_valid=0 before the first rd_en. After rd_en it returns the RAM content. wr_ready=1.
- Store wr_data=0x1122334455667788 with bsel=0x0F to way1 index 5, then read it → the low 4 bytes are 0x55667788 and the high bytes are the prior value.
- fill_start with fill_addr index 0x13 (LINE_BEATS=4), way0, beats 0xA0..0xA3 with one idle fill_valid cycle → the beats land at indices 0x10..0x13. fill_done pulses once. wr_ready=0 throughout the fill.
- During a fill, a store to way1 → it is dropped while wr_ready=0. After wr_ready returns to 1 and the store is retried, a read shows it. A read of way1 during the fill returns correct data in 1 cycle.
- Same-cycle write of 0xFF in byte 0 and read of the same way and index → with CACHEMEM_BYPASS_EN, byte0 reads 0xFF. Without it, the old byte is returned.
- rst_n asserted after 2 fill beats → fill_busy=0 and the FSM is in IDLE. A new fill_start starts at beat 0.
